// File: rtl/vco_freq_counter.sv
// ============================================================================
// vco_freq_counter: counts synchronised VCO rising edges over a programmable
// clk gate window and returns the count through a valid/ack handshake.
// Revision: 1.0
// ============================================================================
`default_nettype none

module vco_freq_counter #(
    parameter int CNT_W       = 16,
    parameter int GATE_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              vco_in,
    input  logic [GATE_W-1:0] gate_cycles,
    input  logic              start,
    input  logic              continuous,
    output logic [CNT_W-1:0]  count,
    output logic              count_valid,
    input  logic              count_ack,
    output logic              overflow,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        GATE = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [GATE_W-1:0] GATE_ONE = {{(GATE_W-1){1'b0}}, 1'b1};

    state_t             state;
    logic [SYNC_STAGES-1:0] sync;
    logic               sync_prev;
    logic               vco_rise;
    logic [GATE_W-1:0]  gate_len;
    logic [GATE_W-1:0]  gate_timer;
    logic [CNT_W-1:0]   edge_cnt;
    logic               ovf_flag;

    logic               cnt_sat;
    logic [CNT_W-1:0]   cnt_next;
    logic               ovf_next;

    // Edge counter saturates; a rise that arrives while saturated marks overflow.
    assign cnt_sat  = (edge_cnt == CNT_MAX);
    assign cnt_next = (vco_rise && !cnt_sat) ? edge_cnt + CNT_ONE : edge_cnt;
    assign ovf_next = ovf_flag | (vco_rise & cnt_sat);

    // Prev flop and edge register freeze with ena so a rise spanning a pause counts once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync      <= '0;
            sync_prev <= 1'b0;
            vco_rise  <= 1'b0;
        end else if (ena) begin
            sync      <= {sync[SYNC_STAGES-2:0], vco_in};
            sync_prev <= sync[SYNC_STAGES-1];
            vco_rise  <= sync[SYNC_STAGES-1] & ~sync_prev;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            gate_len    <= GATE_ONE;
            gate_timer  <= '0;
            edge_cnt    <= '0;
            ovf_flag    <= 1'b0;
            count       <= '0;
            count_valid <= 1'b0;
            overflow    <= 1'b0;
            busy        <= 1'b0;
        end else if (ena) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        gate_len <= (gate_cycles == '0) ? GATE_ONE : gate_cycles;
                        busy     <= 1'b1;
                        state    <= ARM;
                    end
                end
                ARM: begin
                    edge_cnt   <= '0;
                    gate_timer <= gate_len - GATE_ONE;
                    ovf_flag   <= 1'b0;
                    state      <= GATE;
                end
                GATE: begin
                    edge_cnt <= cnt_next;
                    ovf_flag <= ovf_next;
                    if (gate_timer == '0) begin
                        count       <= cnt_next;
                        overflow    <= ovf_next;
                        count_valid <= 1'b1;
                        busy        <= 1'b0;
                        state       <= DONE;
                    end else begin
                        gate_timer <= gate_timer - GATE_ONE;
                    end
                end
                DONE: begin
                    if (count_ack) begin
                        count_valid <= 1'b0;
                        if (continuous) begin
                            busy  <= 1'b1;
                            state <= ARM;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
